io_poll_master: RTL and testbench

Bus initiator for the memory-mapped I/O protocol: drives `mem_cmd`/`mem_addr`/`write_data` toward the I/O decoder and RAM, and samples the shared `read_data` bus. It serves an external single-request handshake port, used by debug/boot logic. When enabled, it also polls the switch address periodically and mirrors any change in the switch byte to the LED address. It sits beside the CPU and drives the bus only while the CPU is held off the bus.

---
 rtl/mem_bus_pkg.sv | 29 ++
 rtl/poll_timer.sv | 54 +++++
 rtl/vDFFE.sv | 23 ++
 rtl/io_poll_master.sv | 192 +++++++++++++++++++
 tb/tb_io_poll_master.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the memory-mapped I/O bus.
//   mem_cmd_t / MREAD / MWRITE / MNONE : bus command encodings
//   SW_ADDR_DEF / LED_ADDR_DEF         : default switch and LED addresses
//   poll_state_t                       : io_poll_master FSM states
//   poll_src_t                         : originator of the in-flight transaction
package mem_bus_pkg;

  typedef logic [1:0] mem_cmd_t;

  localparam mem_cmd_t MREAD  = 2'b01;
  localparam mem_cmd_t MWRITE = 2'b10;
  localparam mem_cmd_t MNONE  = 2'b11;

  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;
  localparam logic [8:0] LED_ADDR_DEF = 9'h100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_WR
  } poll_state_t;

  typedef enum logic {
    SRC_EXT,
    SRC_POLL
  } poll_src_t;

endpackage

// File: rtl/poll_timer.sv
// poll_timer: periodic poll request generator.
//   clk, reset    : clock, synchronous active-high reset
//   enable        : 0 holds the counter at period and drops any pending poll
//   period        : interval in cycles (0 behaves as 1)
//   clear_pending : a poll transaction is starting this cycle
//   poll_pending  : a poll is owed
module poll_timer #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clear_pending,
  output logic                poll_pending
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [PERIOD_W-1:0] period_eff;

  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;

  // Expiry fires when the count would reach zero; a count of zero (fresh
  // from reset) expires immediately. A new expiry in the same cycle as the
  // poll start re-arms the pending flag rather than being lost.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (!enable) begin
      cnt_d  = period;
      pend_d = 1'b0;
    end else if (cnt_q <= PERIOD_W'(1)) begin
      cnt_d  = period_eff;
      pend_d = 1'b1;
    end else begin
      cnt_d  = cnt_q - PERIOD_W'(1);
      pend_d = pend_q & ~clear_pending;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign poll_pending = pend_q;

endmodule

// File: rtl/vDFFE.sv
// vDFFE: n-bit D flip-flop with load enable.
//   clk : clock
//   en  : load enable
//   in  : data in
//   out : registered data
module vDFFE #(
  parameter int unsigned n = 1
) (
  input  logic         clk,
  input  logic         en,
  input  logic [n-1:0] in,
  output logic [n-1:0] out
);

  logic [n-1:0] out_q;

  always_ff @(posedge clk) begin
    if (en) out_q <= in;
  end

  assign out = out_q;

endmodule

// File: rtl/io_poll_master.sv
// io_poll_master: bus initiator serving a single-request port and a
// periodic switch-to-LED mirror.
//   clk, reset            : clock, synchronous active-high reset
//   enable, period        : poll mode enable and interval
//   req_valid/req_ready   : external request handshake
//   req_write/addr/wdata  : external request contents
//   rsp_valid/rsp_rdata   : one-cycle completion pulse and read result
//   mem_cmd/addr/wdata    : registered bus drive
//   read_data             : shared bus read data
//   last_sw               : last polled switch byte
//   busy                  : FSM not idle
module io_poll_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter logic [8:0]  SW_ADDR  = SW_ADDR_DEF,
  parameter logic [8:0]  LED_ADDR = LED_ADDR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [8:0]          req_addr,
  input  logic [15:0]         req_wdata,
  output logic                rsp_valid,
  output logic [15:0]         rsp_rdata,
  output mem_cmd_t            mem_cmd,
  output logic [8:0]          mem_addr,
  output logic [15:0]         write_data,
  input  logic [15:0]         read_data,
  output logic [7:0]          last_sw,
  output logic                busy
);

  poll_state_t state_q, state_d;
  poll_src_t   src_q, src_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic [8:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        first_q, first_d;

  logic        poll_pending;
  logic        poll_start;
  logic        poll_led_wr;
  logic        sw_capture;
  logic        sw_changed;
  logic [7:0]  sw_d;

  poll_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .period       (period),
    .clear_pending(poll_start),
    .poll_pending (poll_pending)
  );

  // The flop cell has no reset pin, so reset is folded into its load path.
  assign sw_capture = (state_q == ST_RD_CAP) && (src_q == SRC_POLL);
  assign sw_d       = reset ? 8'h00 : read_data[7:0];

  vDFFE #(
    .n(8)
  ) u_last_sw (
    .clk(clk),
    .en (reset | sw_capture),
    .in (sw_d),
    .out(last_sw)
  );

  assign sw_changed = (read_data[7:0] != last_sw) || first_q;

  // State register, including the registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_EXT;
      cmd_q       <= MNONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      first_q     <= first_d;
    end
  end

  // Next-state logic; bus values for the next state are computed here so
  // they leave the chip straight from flops.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    poll_start  = 1'b0;
    poll_led_wr = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          src_d  = SRC_EXT;
          addr_d = req_addr;
          if (req_write) begin
            state_d = ST_WR;
            cmd_d   = MWRITE;
            wdata_d = req_wdata;
          end else begin
            state_d = ST_RD_ADDR;
            cmd_d   = MREAD;
            wdata_d = '0;
          end
        end else if (poll_pending) begin
          src_d      = SRC_POLL;
          state_d    = ST_RD_ADDR;
          cmd_d      = MREAD;
          addr_d     = SW_ADDR;
          wdata_d    = '0;
          poll_start = 1'b1;
        end
      end
      ST_RD_ADDR: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        if (src_q == SRC_POLL && sw_changed) begin
          state_d     = ST_WR;
          cmd_d       = MWRITE;
          addr_d      = LED_ADDR;
          wdata_d     = {8'h00, read_data[7:0]};
          poll_led_wr = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cmd_d   = MNONE;
          addr_d  = '0;
          wdata_d = '0;
          if (src_q == SRC_EXT) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = read_data;
          end
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
        cmd_d   = MNONE;
        addr_d  = '0;
        wdata_d = '0;
        if (src_q == SRC_EXT) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cmd_d   = MNONE;
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase

    first_d = first_q;
    if (!enable)          first_d = 1'b1;
    else if (poll_led_wr) first_d = 1'b0;
  end

  // Output logic.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    mem_cmd    = cmd_q;
    mem_addr   = addr_q;
    write_data = wdata_q;
    rsp_valid  = rsp_valid_q;
    rsp_rdata  = rsp_rdata_q;
  end

endmodule

// File: tb/tb_io_poll_master.sv
// tb_io_poll_master: directed stimulus for io_poll_master, checked every
// cycle against a transaction-queue model plus literal expectations.
module tb_io_poll_master;

  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          reset, enable, req_valid, req_write;
  logic          req_ready, rsp_valid, busy;
  logic [PW-1:0] period;
  logic [8:0]    req_addr, mem_addr;
  logic [15:0]   req_wdata, rsp_rdata, write_data, read_data, sw_reg;
  logic [1:0]    mem_cmd;
  logic [7:0]    last_sw;

  always #5 clk = ~clk;

  io_poll_master #(
    .PERIOD_W(PW),
    .SW_ADDR (9'h140),
    .LED_ADDR(9'h100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .period    (period),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .read_data (read_data),
    .last_sw   (last_sw),
    .busy      (busy)
  );

  // Bus slave: switches at 9'h140, a fixed pattern elsewhere, 0 when not reading.
  assign read_data = (mem_cmd == 2'b01) ?
                     ((mem_addr == 9'h140) ? sw_reg : ({7'b0, mem_addr} ^ 16'hC3C3)) :
                     16'h0000;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: queue of expected bus cycles ----------------
  typedef struct packed {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic [1:0]  kind;
  } beat_t;

  localparam logic [1:0] K_PLAIN = 2'd0, K_EXTRD = 2'd1, K_EXTWR = 2'd2, K_POLLCAP = 2'd3;

  function automatic beat_t mk(input logic [1:0] c, input logic [8:0] a,
                               input logic [15:0] w, input logic [1:0] k);
    beat_t r;
    r.cmd = c; r.addr = a; r.wd = w; r.kind = k;
    return r;
  endfunction

  beat_t       q[$];
  beat_t       cur, b;
  int unsigned m_cnt, eff;
  bit          m_pend, m_first, m_rv, armed, idle_now, start, pw, prev_rv;
  logic [7:0]  m_last, sw;
  logic [15:0] m_rd;
  int          n_rd = 0, n_wr = 0, n_rsp = 0, n_after = 0;
  logic [15:0] last_rsp = '0;

  always @(negedge clk) begin
    // compare this cycle's outputs with the model
    if (armed) begin
      cur = (q.size() > 0) ? q[0] : mk(2'b11, 9'h000, 16'h0000, K_PLAIN);
      check("mem_cmd", mem_cmd, cur.cmd);
      check("mem_addr", mem_addr, cur.addr);
      check("write_data", write_data, cur.wd);
      check("req_ready", req_ready, q.size() == 0);
      check("busy", busy, q.size() != 0);
      check("rsp_valid", rsp_valid, m_rv);
      if (m_rv) check("rsp_rdata", rsp_rdata, m_rd);
      check("last_sw", last_sw, m_last);
    end

    // observation counters for the directed checks
    if (mem_cmd == 2'b01) n_rd++;
    if (mem_cmd == 2'b10) n_wr++;
    if (rsp_valid) begin n_rsp++; last_rsp = rsp_rdata; end
    if (prev_rv && mem_cmd == 2'b01 && mem_addr == 9'h140) n_after++;
    prev_rv = rsp_valid;

    // advance the model across the coming clock edge
    if (reset) begin
      q.delete();
      m_cnt = 0; m_pend = 0; m_first = 1; m_last = 8'h00;
      m_rv = 0; m_rd = 16'h0000; armed = 1;
    end else begin
      idle_now = (q.size() == 0);
      start = 0; pw = 0; m_rv = 0;
      if (!idle_now) begin
        b = q.pop_front();
        case (b.kind)
          K_EXTRD: begin m_rv = 1; m_rd = read_data; end
          K_EXTWR: begin m_rv = 1; m_rd = 16'h0000; end
          K_POLLCAP: begin
            sw = read_data[7:0];
            if (sw != m_last || m_first) begin
              q.push_back(mk(2'b10, 9'h100, {8'h00, sw}, K_PLAIN));
              pw = 1;
            end
            m_last = sw;
          end
          default: ;
        endcase
      end else if (req_valid) begin
        if (req_write) begin
          q.push_back(mk(2'b10, req_addr, req_wdata, K_EXTWR));
        end else begin
          q.push_back(mk(2'b01, req_addr, 16'h0000, K_PLAIN));
          q.push_back(mk(2'b01, req_addr, 16'h0000, K_EXTRD));
        end
      end else if (m_pend) begin
        q.push_back(mk(2'b01, 9'h140, 16'h0000, K_PLAIN));
        q.push_back(mk(2'b01, 9'h140, 16'h0000, K_POLLCAP));
        start = 1;
      end

      eff = (period == 0) ? 1 : period;
      if (!enable) begin
        m_cnt = period; m_pend = 0; m_first = 1;
      end else begin
        if (pw) m_first = 0;
        if (m_cnt <= 1) begin
          m_cnt = eff; m_pend = 1;
        end else begin
          m_cnt = m_cnt - 1;
          if (start) m_pend = 0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int s_rd, s_wr, s_rsp, s_after;

  task automatic snap();
    s_rd = n_rd; s_wr = n_wr; s_rsp = n_rsp; s_after = n_after;
  endtask

  initial begin
    reset = 1; enable = 0; period = 16'd4;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    sw_reg = 16'h003C;
    tick(3);
    reset = 0;
    tick(1);
    check("reset_cmd", mem_cmd, 2'b11);
    check("reset_ready", req_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rsp", rsp_valid, 1'b0);
    check("reset_rdata", rsp_rdata, 16'h0000);
    check("reset_last_sw", last_sw, 8'h00);

    // external write
    snap();
    req_valid = 1; req_write = 1; req_addr = 9'h100; req_wdata = 16'h00A5;
    tick(1);
    req_valid = 0;
    check("extwr_cmd", mem_cmd, 2'b10);
    check("extwr_data", write_data, 16'h00A5);
    tick(1);
    check("extwr_rsp", rsp_valid, 1'b1);
    check("extwr_rdata", rsp_rdata, 16'h0000);
    check("extwr_idle", mem_cmd, 2'b11);
    tick(2);
    check("extwr_wrcycles", n_wr - s_wr, 1);

    // external read of the switch address
    sw_reg = 16'h005A;
    snap();
    req_valid = 1; req_write = 0; req_addr = 9'h140;
    tick(1);
    req_valid = 0;
    check("extrd_cmd1", mem_cmd, 2'b01);
    tick(1);
    check("extrd_cmd2", mem_cmd, 2'b01);
    tick(1);
    check("extrd_rsp", rsp_valid, 1'b1);
    check("extrd_rdata", rsp_rdata, 16'h005A);
    tick(2);
    check("extrd_rdcycles", n_rd - s_rd, 2);

    // external read elsewhere: 9'h0A3 ^ 16'hC3C3 = 16'hC360
    req_valid = 1; req_addr = 9'h0A3;
    tick(1);
    req_valid = 0;
    tick(2);
    check("extrd2_rdata", rsp_rdata, 16'hC360);
    tick(2);

    // polling with steady switches: one LED write, then reads only
    sw_reg = 16'h003C; period = 16'd4; enable = 1;
    snap();
    tick(30);
    check("poll_writes", n_wr - s_wr, 1);
    check("poll_last_sw", last_sw, 8'h3C);
    check("poll_reads", (n_rd - s_rd) >= 10, 1'b1);

    // switch change -> exactly one more LED write
    sw_reg = 16'h0081;
    snap();
    tick(12);
    check("chg_writes", n_wr - s_wr, 1);
    check("chg_last_sw", last_sw, 8'h81);

    // collision: request arrives with a freshly pending poll
    enable = 0;
    tick(4);
    enable = 1;
    tick(4);
    snap();
    req_valid = 1; req_write = 0; req_addr = 9'h0A3;
    tick(1);
    req_valid = 0;
    check("coll_ext_first", mem_addr, 9'h0A3);
    tick(6);
    check("coll_rdata", last_rsp, 16'hC360);
    check("coll_poll_after", n_after - s_after, 1);

    // reset during RD_CAP of an external read
    enable = 0;
    tick(4);
    req_valid = 1; req_write = 0; req_addr = 9'h0A3;
    tick(1);
    req_valid = 0;
    tick(1);
    check("rstcap_in_read", mem_cmd, 2'b01);
    reset = 1;
    tick(1);
    reset = 0;
    check("rstcap_cmd", mem_cmd, 2'b11);
    check("rstcap_ready", req_ready, 1'b1);
    snap();
    tick(5);
    check("rstcap_no_rsp", n_rsp - s_rsp, 0);

    // period 0: back-to-back polls
    period = 16'd0; enable = 1;
    snap();
    tick(24);
    check("p0_reads", (n_rd - s_rd) >= 12, 1'b1);
    check("p0_writes", n_wr - s_wr, 1);
    check("p0_last_sw", last_sw, 8'h81);
    enable = 0;
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
